find_max_sequencer: RTL and testbench

//  Sequences the find_MAX datapath: accepts operation descriptors (count) and data triples,

---
 rtl/find_max_sequencer_pkg.sv | 23 ++
 rtl/find_max_sequencer_if.sv | 44 ++++
 rtl/find_max_sequencer_wait_timer.sv | 34 +++
 rtl/find_max_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_find_max_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/find_max_sequencer_pkg.sv
// Shared types and constants for the find_MAX sequencer: FSM states, wait-counter type,
// datapath widths and the default gap/settle lengths.
package find_max_seq_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 3;

    localparam int GAP_CYCLES_DEF    = 1;
    localparam int SETTLE_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        GAP,
        SETTLE,
        RESULT
    } state_t;

    typedef logic [3:0] wait_cnt_t;

endpackage

// File: rtl/find_max_sequencer_if.sv
// Host/datapath-facing bundle of the find_MAX sequencer; master is the host/pattern side,
// slave is the sequencer itself.
interface find_max_sequencer_if;
    import find_max_seq_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic [CNT_W-1:0]  op_count;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data_a;
    logic [DATA_W-1:0] in_data_b;
    logic [DATA_W-1:0] in_data_c;
    logic [DATA_W-1:0] in_instruction;
    logic [SEL_W-1:0]  in_select;
    logic              fm_start;
    logic [CNT_W-1:0]  fm_count;
    logic              fm_valid;
    logic [DATA_W-1:0] fm_data_a;
    logic [DATA_W-1:0] fm_data_b;
    logic [DATA_W-1:0] fm_data_c;
    logic [DATA_W-1:0] fm_instruction;
    logic [SEL_W-1:0]  fm_select;
    logic [DATA_W-1:0] fm_second_maximum;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;

    modport master (
        output op_valid, op_count, in_valid, in_data_a, in_data_b, in_data_c,
               in_instruction, in_select, res_ready, fm_second_maximum,
        input  op_ready, in_ready, fm_start, fm_count, fm_valid, fm_data_a, fm_data_b,
               fm_data_c, fm_instruction, fm_select, res_valid, res_data, busy
    );

    modport slave (
        input  op_valid, op_count, in_valid, in_data_a, in_data_b, in_data_c,
               in_instruction, in_select, res_ready, fm_second_maximum,
        output op_ready, in_ready, fm_start, fm_count, fm_valid, fm_data_a, fm_data_b,
               fm_data_c, fm_instruction, fm_select, res_valid, res_data, busy
    );

endinterface

// File: rtl/find_max_sequencer_wait_timer.sv
// Loadable 4-bit down-counter with a done flag; saturates at zero. Shared by the GAP and
// SETTLE phases of the sequencer.
module fms_wait_timer
    import find_max_seq_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  wait_cnt_t load_val,
    output logic      done
);

    wait_cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/find_max_sequencer.sv
// Sequencer in front of find_MAX: start pulse, paced triple stream, settle wait, result capture.
// Optional FMS_OP_CNT_EN adds a 16-bit count of completed result handshakes (op_done_cnt).
module find_max_sequencer
    import find_max_seq_pkg::*;
#(
    parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    find_max_sequencer_if.slave   bus
`ifdef FMS_OP_CNT_EN
    ,
    output logic [15:0]           op_done_cnt
`endif
);

    // Timer value 0 means "finish this cycle", so each phase loads its length minus one.
    // From SEND the last fm_valid cycle is itself the first SETTLE cycle, hence the extra one.
    localparam wait_cnt_t GAP_LOAD          = wait_cnt_t'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam wait_cnt_t SETTLE_LOAD_BEAT  = wait_cnt_t'(SETTLE_CYCLES);
    localparam wait_cnt_t SETTLE_LOAD_START = wait_cnt_t'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              fm_start_q, fm_start_d;
    logic [CNT_W-1:0]  fm_count_q, fm_count_d;
    logic              fm_valid_q, fm_valid_d;
    logic [DATA_W-1:0] fm_a_q, fm_a_d, fm_b_q, fm_b_d, fm_c_q, fm_c_d;
    logic [DATA_W-1:0] fm_instr_q, fm_instr_d;
    logic [SEL_W-1:0]  fm_sel_q, fm_sel_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    logic      tmr_load;
    wait_cnt_t tmr_val;
    logic      tmr_done;
    logic      last_beat;

    fms_wait_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign last_beat = (({1'b0, beat_q} + 4'd1) == {1'b0, count_q});

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        beat_d     = beat_q;
        fm_start_d = 1'b0;
        fm_count_d = '0;
        fm_valid_d = 1'b0;
        fm_a_d     = '0;
        fm_b_d     = '0;
        fm_c_d     = '0;
        fm_instr_d = '0;
        fm_sel_d   = '0;
        res_data_d = res_data_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    count_d    = bus.op_count;
                    beat_d     = '0;
                    fm_start_d = 1'b1;
                    fm_count_d = bus.op_count;
                    state_d    = START;
                end
            end
            START: begin
                if (count_q == '0) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD_START;
                    state_d  = SETTLE;
                end else begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.in_valid) begin
                    fm_valid_d = 1'b1;
                    fm_a_d     = bus.in_data_a;
                    fm_b_d     = bus.in_data_b;
                    fm_c_d     = bus.in_data_c;
                    fm_instr_d = bus.in_instruction;
                    fm_sel_d   = bus.in_select;
                    beat_d     = beat_q + 3'd1;
                    if (last_beat) begin
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LOAD_BEAT;
                        state_d  = SETTLE;
                    end else if (GAP_CYCLES > 0) begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        state_d  = GAP;
                    end
                end
            end
            GAP: begin
                if (tmr_done) begin
                    state_d = SEND;
                end
            end
            SETTLE: begin
                if (tmr_done) begin
                    res_data_d = bus.fm_second_maximum;
                    state_d    = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            beat_q     <= '0;
            fm_start_q <= 1'b0;
            fm_count_q <= '0;
            fm_valid_q <= 1'b0;
            fm_a_q     <= '0;
            fm_b_q     <= '0;
            fm_c_q     <= '0;
            fm_instr_q <= '0;
            fm_sel_q   <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            beat_q     <= beat_d;
            fm_start_q <= fm_start_d;
            fm_count_q <= fm_count_d;
            fm_valid_q <= fm_valid_d;
            fm_a_q     <= fm_a_d;
            fm_b_q     <= fm_b_d;
            fm_c_q     <= fm_c_d;
            fm_instr_q <= fm_instr_d;
            fm_sel_q   <= fm_sel_d;
            res_data_q <= res_data_d;
        end
    end

    assign bus.op_ready       = (state_q == IDLE);
    assign bus.in_ready       = (state_q == SEND);
    assign bus.res_valid      = (state_q == RESULT);
    assign bus.busy           = (state_q != IDLE);
    assign bus.res_data       = res_data_q;
    assign bus.fm_start       = fm_start_q;
    assign bus.fm_count       = fm_count_q;
    assign bus.fm_valid       = fm_valid_q;
    assign bus.fm_data_a      = fm_a_q;
    assign bus.fm_data_b      = fm_b_q;
    assign bus.fm_data_c      = fm_c_q;
    assign bus.fm_instruction = fm_instr_q;
    assign bus.fm_select      = fm_sel_q;

`ifdef FMS_OP_CNT_EN
    logic [15:0] op_cnt_q, op_cnt_d;

    always_comb begin
        op_cnt_d = op_cnt_q;
        if (state_q == RESULT && bus.res_ready) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else begin
            op_cnt_q <= op_cnt_d;
        end
    end

    assign op_done_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_find_max_sequencer.sv
// Self-checking bench for find_max_sequencer: directed ops plus randomized ops, checked
// cycle by cycle against a timestamp-based model of the sequencing rules.
module tb_find_max_sequencer;
    import find_max_seq_pkg::*;

    localparam int GAP  = 1;
    localparam int SETT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;
    int   ops_done = 0;

    logic [7:0] fa [3] = '{8'd10, 8'd5,  8'd7};
    logic [7:0] fb [3] = '{8'd20, 8'd40, 8'd7};
    logic [7:0] fc [3] = '{8'd30, 8'd1,  8'd7};

    find_max_sequencer_if bus_if ();

`ifdef FMS_OP_CNT_EN
    logic [15:0] op_done_cnt;
`endif

    find_max_sequencer #(
        .GAP_CYCLES    (GAP),
        .SETTLE_CYCLES (SETT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
`ifdef FMS_OP_CNT_EN
        ,
        .op_done_cnt (op_done_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // find_MAX stand-in: an output that differs every cycle exposes the exact sampling edge.
    function automatic logic [7:0] sm_at(input int c);
        return 8'(c * 37 + 11);
    endfunction

    assign bus_if.fm_second_maximum = sm_at(cyc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_op_ready"},  32'(bus_if.op_ready), 32'd1);
        chk({tag, "_in_ready"},  32'(bus_if.in_ready), 32'd0);
        chk({tag, "_busy"},      32'(bus_if.busy), 32'd0);
        chk({tag, "_fm_start"},  32'(bus_if.fm_start), 32'd0);
        chk({tag, "_fm_count"},  32'(bus_if.fm_count), 32'd0);
        chk({tag, "_fm_valid"},  32'(bus_if.fm_valid), 32'd0);
        chk({tag, "_fm_abc"},    32'({bus_if.fm_data_a, bus_if.fm_data_b, bus_if.fm_data_c}), 32'd0);
        chk({tag, "_fm_is"},     32'({bus_if.fm_instruction, bus_if.fm_select}), 32'd0);
        chk({tag, "_res_valid"}, 32'(bus_if.res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(bus_if.res_data), 32'd0);
`ifdef FMS_OP_CNT_EN
        chk({tag, "_op_done_cnt"}, 32'(op_done_cnt), 32'd0);
`endif
    endtask

    // Called at a negedge with the DUT idle. Runs one operation of n triples end to end.
    task automatic run_op(input int n, input bit fixed, input int stall_beat, input int stall_len,
                          input bit rnd_stall, input int hold, input int abort_beat);
        int p, ready_from, beats, res_cyc, sample_cyc, c, stall_left;
        bit exp_v, exp_v_nx, exp_rdy, want, reached;
        logic [7:0] ta, tb_v, tc, ti, ea, eb, ec, ei;
        logic [2:0] ts, es;
        logic [7:0] hold_data;

        chk("idle_op_ready", 32'(bus_if.op_ready), 32'd1);
        chk("idle_busy",     32'(bus_if.busy), 32'd0);
        chk("idle_in_ready", 32'(bus_if.in_ready), 32'd0);
        bus_if.op_valid = 1'b1;
        bus_if.op_count = 3'(n);
        bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.op_valid = 1'b0;
        bus_if.op_count = 3'($urandom);
        bus_if.in_valid = 1'b0;

        p = cyc;
        ready_from = p + 1;
        beats = 0;
        exp_v = 1'b0;
        stall_left = 0;
        reached = 1'b0;
        ea = '0; eb = '0; ec = '0; ei = '0; es = '0;
        res_cyc    = (n == 0) ? p + SETT + 1 : -1;
        sample_cyc = p + SETT;
        ta = fixed ? fa[0] : 8'($urandom);
        tb_v = fixed ? fb[0] : 8'($urandom);
        tc = fixed ? fc[0] : 8'($urandom);
        ti = 8'($urandom);
        ts = 3'($urandom);

        for (int k = 0; k < 400; k++) begin
            c = cyc;
            if (c == res_cyc) begin
                reached = 1'b1;
                break;
            end
            exp_rdy = (beats < n) && (c >= ready_from);
            chk("in_ready",  32'(bus_if.in_ready), 32'(exp_rdy));
            chk("op_ready",  32'(bus_if.op_ready), 32'd0);
            chk("fm_start",  32'(bus_if.fm_start), 32'(c == p));
            chk("fm_count",  32'(bus_if.fm_count), (c == p) ? 32'(n) : 32'd0);
            chk("fm_valid",  32'(bus_if.fm_valid), 32'(exp_v));
            chk("fm_abc", 32'({bus_if.fm_data_a, bus_if.fm_data_b, bus_if.fm_data_c}),
                exp_v ? 32'({ea, eb, ec}) : 32'd0);
            chk("fm_is", 32'({bus_if.fm_instruction, bus_if.fm_select}),
                exp_v ? 32'({ei, es}) : 32'd0);
            chk("res_valid_early", 32'(bus_if.res_valid), 32'd0);

            want = 1'b0;
            if (beats < n) begin
                if (stall_left > 0) stall_left--;
                else want = rnd_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            bus_if.in_valid       = want;
            bus_if.in_data_a      = ta;
            bus_if.in_data_b      = tb_v;
            bus_if.in_data_c      = tc;
            bus_if.in_instruction = ti;
            bus_if.in_select      = ts;

            exp_v_nx = 1'b0;
            if (want && exp_rdy) begin
                exp_v_nx = 1'b1;
                ea = ta; eb = tb_v; ec = tc; ei = ti; es = ts;
                beats++;
                if (beats == n) begin
                    sample_cyc = c + 1 + SETT;
                    res_cyc    = c + 2 + SETT;
                end else begin
                    ready_from = c + 1 + GAP;
                end
                if (beats == stall_beat) stall_left = stall_len;
                ta = (fixed && beats < 3) ? fa[beats] : 8'($urandom);
                tb_v = (fixed && beats < 3) ? fb[beats] : 8'($urandom);
                tc = (fixed && beats < 3) ? fc[beats] : 8'($urandom);
                ti = 8'($urandom);
                ts = 3'($urandom);
            end
            @(negedge clk);
            bus_if.in_valid = 1'b0;
            exp_v = exp_v_nx;

            if (abort_beat > 0 && beats == abort_beat && exp_v) begin
                chk("abort_fm_valid", 32'(bus_if.fm_valid), 32'd1);
                chk("abort_busy",     32'(bus_if.busy), 32'd1);
                #2 rst_n = 1'b0;
                #1 chk_reset_outputs("async_rst");
                ops_done = 0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end

        chk("res_in_time", 32'(reached), 32'd1);
        if (!reached) return;
        chk("res_valid",     32'(bus_if.res_valid), 32'd1);
        chk("res_data",      32'(bus_if.res_data), 32'(sm_at(sample_cyc)));
        chk("res_op_ready",  32'(bus_if.op_ready), 32'd0);
        chk("res_busy",      32'(bus_if.busy), 32'd1);
        chk("res_fm_valid",  32'(bus_if.fm_valid), 32'd0);
        chk("beats_sent",    32'(beats), 32'(n));
        hold_data = sm_at(sample_cyc);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_res_valid", 32'(bus_if.res_valid), 32'd1);
            chk("hold_res_data",  32'(bus_if.res_data), 32'(hold_data));
            chk("hold_op_ready",  32'(bus_if.op_ready), 32'd0);
        end
        bus_if.res_ready = 1'b1;
        @(negedge clk);
        bus_if.res_ready = 1'b0;
        ops_done++;
        chk("post_res_valid", 32'(bus_if.res_valid), 32'd0);
        chk("post_op_ready",  32'(bus_if.op_ready), 32'd1);
        chk("post_busy",      32'(bus_if.busy), 32'd0);
`ifdef FMS_OP_CNT_EN
        chk("op_done_cnt", 32'(op_done_cnt), 32'(16'(ops_done)));
`endif
    endtask

    initial begin
        bus_if.op_valid = 1'b0;
        bus_if.op_count = '0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data_a = '0;
        bus_if.in_data_b = '0;
        bus_if.in_data_c = '0;
        bus_if.in_instruction = '0;
        bus_if.in_select = '0;
        bus_if.res_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3, 1'b1, 0, 0, 1'b0, 0, 0);
        run_op(0, 1'b0, 0, 0, 1'b0, 0, 0);
        run_op(7, 1'b0, 3, 5, 1'b0, 0, 0);
        run_op(2, 1'b0, 0, 0, 1'b0, 10, 0);
        run_op(4, 1'b0, 0, 0, 1'b0, 0, 2);
        run_op(4, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            run_op(int'($urandom_range(0, 7)), 1'b0, 0, 0, 1'b1, int'($urandom_range(0, 3)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
